mtime_counter: RTL and testbench
================================

MTIME_COUNTER -- requirements
Module: mtime_counter

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, giving the width of the div input and the prescaler.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port div  input  PRESC_W  prescale ratio; counter ticks once per max(div,1) non-halted cycles.
REQ-005 SHALL have port halt  input  1  debug freeze; when 1, prescaler and counter hold.
REQ-006 SHALL have port wr_valid  input  1  software write request.
REQ-007 SHALL have port wr_hi  input  1  write selects high word (1) or low word (0).
REQ-008 SHALL have port wr_wmask  input  4  per-byte write enables.
REQ-009 SHALL have port wr_data  input  32  write data.
REQ-010 SHALL have port wr_ready  output  1  one-cycle write acknowledge.
REQ-011 SHALL have port snap_req  input  1  capture request for atomic 64-bit read.
REQ-012 SHALL have port timer_counter  output  64  live mtime value, the timer_counter input of the CLINT.
REQ-013 SHALL have port timer_snapshot  output  64  value captured on the last snap_req.
REQ-014 SHALL have port tick  output  1  registered pulse, high in the cycle after each increment.
REQ-015 SHALL have port wrap  output  1  registered pulse, high in the cycle after the counter rolls from all-ones to zero.

Function
REQ-016 SHALL keep a PRESC_W-bit prescaler and generate an increment enable when halt=0 and prescaler >= div-1, treating div=0 as div=1.
REQ-017 SHALL clear the prescaler to 0 on an increment and add 1 to it otherwise when halt=0, so that a decrease of div below the current prescaler value yields an increment on the next non-halted cycle.
REQ-018 SHALL add 1 to the 64-bit counter on each increment enable, carrying from bit 31 into bit 32 within the same cycle.
REQ-019 SHALL roll the counter from 64'hFFFF_FFFF_FFFF_FFFF to 0 and assert wrap for exactly one cycle afterwards.
REQ-020 SHALL hold the prescaler and counter and hold tick at 0 while halt=1, and SHALL resume with the prescaler value held at entry to halt.
REQ-021 SHALL accept a write when wr_valid=1 and wr_ready=0 and SHALL assert wr_ready in the following cycle only, so that wr_ready is never high for two consecutive cycles.
REQ-022 SHALL update only the bytes of the selected word whose wr_wmask bits are set.
REQ-023 SHALL, when a low-word write coincides with an increment, store the written low bytes, leave unmasked low bytes unincremented, suppress the increment and its carry, and clear the prescaler.
REQ-024 SHALL, when a high-word write coincides with an increment, store the written high bytes, increment the low word, and discard any carry into masked high bytes (unmasked high bytes take carry).
REQ-025 SHALL accept writes while halt=1.
REQ-026 SHALL load timer_snapshot with the counter value present in the cycle snap_req=1; the new value SHALL be visible one cycle later.
REQ-027 SHALL hold timer_snapshot stable between requests.
REQ-028 SHALL drive timer_counter directly from the counter register with no added latency.

Reset
REQ-029 SHALL, while resetn=0, clear the counter, prescaler, timer_snapshot, tick, wrap and wr_ready to 0.
REQ-030 SHALL abandon any write in progress during reset, so that no wr_ready is issued for it.
REQ-031 SHALL make its first increment after reset take max(div,1) non-halted cycles.

Configuration
REQ-032 SHALL gate write support with macro MTIME_WRITE_EN.
REQ-033 SHALL, with MTIME_WRITE_EN defined, behave as REQ-021..REQ-025.
REQ-034 SHALL, with MTIME_WRITE_EN undefined, still generate wr_ready per REQ-021 so the bus does not stall, while ignoring wr_data, wr_wmask and wr_hi and leaving counter and prescaler unaffected.

Verification
REQ-035 SHALL cover: div=4, halt=0 after reset -> timer_counter=1 after 4 cycles, =3 after 12 cycles, and tick pulses every 4th cycle.
REQ-036 SHALL cover: div=0, then div=1 -> counter increments every cycle in both cases.
REQ-037 SHALL cover: counter loaded to 64'h0000_0000_FFFF_FFFF, div=1 -> next value 64'h0000_0001_0000_0000; loaded to all-ones -> next value 0 with a single wrap pulse.
REQ-038 SHALL cover: low-word write of 32'h1234_5678 with wmask=4'b0011 on an increment cycle, counter low=32'hAAAA_AAAA -> low=32'hAAAA_5678, no increment, prescaler=0, wr_ready high exactly one cycle.
REQ-039 SHALL cover: halt=1 for 10 cycles, div=3 -> counter unchanged and tick=0; after halt drops, next increment follows the preserved prescaler phase.
REQ-040 SHALL cover: snap_req with counter=64'h5 followed by 20 increments -> timer_snapshot=64'h5 throughout; with MTIME_WRITE_EN undefined, any write -> wr_ready pulses and the counter is unaffected.

Source files
------------

// File: rtl/mtime_counter.sv
// 64-bit mtime counter with prescaler, debug halt, byte-masked software writes and
// atomic snapshot. Write support is compiled in only when MTIME_WRITE_EN is defined.
module mtime_counter #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PRESC_W-1:0] div,
  input  logic               halt,
  input  logic               wr_valid,
  input  logic               wr_hi,
  input  logic [3:0]         wr_wmask,
  input  logic [31:0]        wr_data,
  output logic               wr_ready,
  input  logic               snap_req,
  output logic [63:0]        timer_counter,
  output logic [63:0]        timer_snapshot,
  output logic               tick,
  output logic               wrap
);

  localparam logic [PRESC_W-1:0] PrescOne = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [63:0]        cnt_q, cnt_d;
  logic [63:0]        snap_q;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               wr_ready_q;

  logic [PRESC_W-1:0] div_eff;
  logic               inc_en;
  logic               wr_acc;
  logic               carry;
  logic [31:0]        lo_inc, hi_inc;

  assign div_eff = (div == '0) ? PrescOne : div;
  assign inc_en  = !halt && (presc_q >= (div_eff - PrescOne));
  // wr_ready_q blocks back-to-back acceptance so the acknowledge never stretches.
  assign wr_acc  = wr_valid && !wr_ready_q;
  assign carry   = inc_en && (&cnt_q[31:0]);
  assign lo_inc  = cnt_q[31:0] + {31'b0, inc_en};
  assign hi_inc  = cnt_q[63:32] + {31'b0, carry};

`ifdef MTIME_WRITE_EN
  logic [31:0] word_wr;

  always_comb begin
    word_wr = wr_hi ? hi_inc : cnt_q[31:0];
    for (int b = 0; b < 4; b++) begin
      if (wr_wmask[b]) begin
        word_wr[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_hi, wr_wmask, wr_data};
`endif

  always_comb begin
    cnt_d  = {hi_inc, lo_inc};
    tick_d = inc_en;
    wrap_d = carry && (&cnt_q[63:32]);
    if (halt) begin
      presc_d = presc_q;
    end else if (inc_en) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PrescOne;
    end
`ifdef MTIME_WRITE_EN
    if (wr_acc) begin
      if (wr_hi) begin
        // Low word still counts; masked high bytes drop any carry.
        cnt_d  = {word_wr, lo_inc};
        wrap_d = wrap_d && (word_wr == '0);
      end else begin
        // A low-word write wins over a coincident increment.
        cnt_d  = {cnt_q[63:32], word_wr};
        tick_d = 1'b0;
        wrap_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      wr_ready_q <= wr_acc;
      if (snap_req) begin
        snap_q <= cnt_q;
      end
    end
  end

  assign timer_counter  = cnt_q;
  assign timer_snapshot = snap_q;
  assign tick           = tick_q;
  assign wrap           = wrap_q;
  assign wr_ready       = wr_ready_q;

endmodule

// File: tb/tb_mtime_counter.sv
// Directed bench for mtime_counter: table of prescaler/halt rows plus hand-written
// sequences for snapshot, write handshake, carry, wrap and write/increment collisions.
module tb_mtime_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] div;
  logic        halt;
  logic        wr_valid;
  logic        wr_hi;
  logic [3:0]  wr_wmask;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        snap_req;
  logic [63:0] timer_counter;
  logic [63:0] timer_snapshot;
  logic        tick;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mtime_counter #(.PRESC_W(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .div           (div),
    .halt          (halt),
    .wr_valid      (wr_valid),
    .wr_hi         (wr_hi),
    .wr_wmask      (wr_wmask),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .snap_req      (snap_req),
    .timer_counter (timer_counter),
    .timer_snapshot(timer_snapshot),
    .tick          (tick),
    .wrap          (wrap)
  );

  typedef struct {
    logic [15:0] div;
    logic        halt;
    int          cycles;
    logic [63:0] cnt;
    int          ticks;
    logic        last_tick;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    div      = '0;
    halt     = 1'b0;
    wr_valid = 1'b0;
    wr_hi    = 1'b0;
    wr_wmask = '0;
    wr_data  = '0;
    snap_req = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

`ifdef MTIME_WRITE_EN
  task automatic wr(input logic hi, input logic [3:0] mask, input logic [31:0] data);
    wr_hi    = hi;
    wr_wmask = mask;
    wr_data  = data;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("wr_ack", {63'b0, wr_ready}, 64'd1);
    step();
  endtask
`endif

  initial begin
    vecs[0]  = '{16'd4, 1'b0, 4,  64'd1,  1, 1'b1};
    vecs[1]  = '{16'd4, 1'b0, 8,  64'd3,  2, 1'b1};
    vecs[2]  = '{16'd4, 1'b0, 2,  64'd3,  0, 1'b0};
    vecs[3]  = '{16'd4, 1'b1, 10, 64'd3,  0, 1'b0};
    vecs[4]  = '{16'd4, 1'b0, 1,  64'd3,  0, 1'b0};
    vecs[5]  = '{16'd4, 1'b0, 1,  64'd4,  1, 1'b1};
    vecs[6]  = '{16'd0, 1'b0, 3,  64'd7,  3, 1'b1};
    vecs[7]  = '{16'd1, 1'b0, 3,  64'd10, 3, 1'b1};
    vecs[8]  = '{16'd3, 1'b0, 2,  64'd10, 0, 1'b0};
    vecs[9]  = '{16'd3, 1'b1, 10, 64'd10, 0, 1'b0};
    vecs[10] = '{16'd3, 1'b0, 1,  64'd11, 1, 1'b1};
    vecs[11] = '{16'd8, 1'b0, 5,  64'd11, 0, 1'b0};
    vecs[12] = '{16'd2, 1'b0, 1,  64'd12, 1, 1'b1};
    vecs[13] = '{16'd2, 1'b0, 4,  64'd14, 2, 1'b1};

    // Reset state, with a write request pending during reset.
    do_reset();
    resetn   = 1'b0;
    wr_valid = 1'b1;
    step();
    chk("rst_counter", timer_counter, 64'd0);
    chk("rst_snapshot", timer_snapshot, 64'd0);
    chk("rst_tick", {63'b0, tick}, 64'd0);
    chk("rst_wrap", {63'b0, wrap}, 64'd0);
    chk("rst_wr_ready", {63'b0, wr_ready}, 64'd0);
    wr_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();
    chk("rst_abandon_ready", {63'b0, wr_ready}, 64'd0);
    do_reset();

    foreach (vecs[i]) begin
      int nt;
      nt   = 0;
      div  = vecs[i].div;
      halt = vecs[i].halt;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        if (tick) nt++;
      end
      chk($sformatf("row%0d_counter", i), timer_counter, vecs[i].cnt);
      chk($sformatf("row%0d_ticks", i), 64'(nt), 64'(vecs[i].ticks));
      chk($sformatf("row%0d_tick", i), {63'b0, tick}, {63'b0, vecs[i].last_tick});
      chk($sformatf("row%0d_wrap", i), {63'b0, wrap}, 64'd0);
    end

    // Snapshot holds across later increments; reset clears a non-zero counter.
    do_reset();
    chk("reset_clears_counter", timer_counter, 64'd0);
    div = 16'd1;
    for (int c = 0; c < 5; c++) step();
    chk("snap_pre_counter", timer_counter, 64'd5);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("snap_value", timer_snapshot, 64'd5);
    chk("snap_counter", timer_counter, 64'd6);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("snap_hold", timer_snapshot, 64'd5);
    end
    chk("snap_post_counter", timer_counter, 64'd26);

    // Held wr_valid must give an alternating acknowledge, also while halted.
    halt     = 1'b1;
    wr_hi    = 1'b0;
    wr_wmask = 4'hF;
    wr_data  = 32'hDEAD_BEEF;
    wr_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("ready_alternate", {63'b0, wr_ready}, (c % 2 == 0) ? 64'd1 : 64'd0);
    end
    wr_valid = 1'b0;
    step();
    chk("ready_idle", {63'b0, wr_ready}, 64'd0);
`ifdef MTIME_WRITE_EN
    chk("write_halted", timer_counter, 64'h0000_0000_DEAD_BEEF);

    // Carry from bit 31 into bit 32.
    wr(1'b1, 4'hF, 32'h0);
    wr(1'b0, 4'hF, 32'hFFFF_FFFF);
    chk("carry_load", timer_counter, 64'h0000_0000_FFFF_FFFF);
    halt = 1'b0;
    step();
    chk("carry_result", timer_counter, 64'h0000_0001_0000_0000);
    chk("carry_tick", {63'b0, tick}, 64'd1);
    chk("carry_wrap", {63'b0, wrap}, 64'd0);

    // Roll over from all-ones.
    halt = 1'b1;
    wr(1'b1, 4'hF, 32'hFFFF_FFFF);
    wr(1'b0, 4'hF, 32'hFFFF_FFFF);
    halt = 1'b0;
    step();
    chk("wrap_counter", timer_counter, 64'd0);
    chk("wrap_pulse", {63'b0, wrap}, 64'd1);
    step();
    chk("wrap_next_counter", timer_counter, 64'd1);
    chk("wrap_single", {63'b0, wrap}, 64'd0);

    // Low-word write on an increment cycle suppresses the increment.
    halt = 1'b1;
    div  = 16'd2;
    wr(1'b0, 4'hF, 32'hAAAA_AAAA);
    wr(1'b1, 4'hF, 32'h0);
    halt = 1'b0;
    step();
    chk("lo_pre", timer_counter, 64'h0000_0000_AAAA_AAAA);
    wr_hi    = 1'b0;
    wr_wmask = 4'b0011;
    wr_data  = 32'h1234_5678;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("lo_coll_counter", timer_counter, 64'h0000_0000_AAAA_5678);
    chk("lo_coll_ready", {63'b0, wr_ready}, 64'd1);
    chk("lo_coll_tick", {63'b0, tick}, 64'd0);
    step();
    chk("lo_coll_ready_drop", {63'b0, wr_ready}, 64'd0);
    chk("lo_coll_presc_cleared", timer_counter, 64'h0000_0000_AAAA_5678);
    step();
    chk("lo_coll_resume", timer_counter, 64'h0000_0000_AAAA_5679);

    // High-word write on an increment whose carry reaches the high word.
    halt = 1'b1;
    wr(1'b0, 4'hF, 32'hFFFF_FFFF);
    wr(1'b1, 4'hF, 32'h1122_33FF);
    halt = 1'b0;
    step();
    chk("hi_pre", timer_counter, 64'h1122_33FF_FFFF_FFFF);
    wr_hi    = 1'b1;
    wr_wmask = 4'b0001;
    wr_data  = 32'h0000_00AA;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("hi_coll_counter", timer_counter, 64'h1122_34AA_0000_0000);
    chk("hi_coll_ready", {63'b0, wr_ready}, 64'd1);
`else
    chk("write_ignored", timer_counter, 64'd26);
    halt = 1'b0;
    step();
    chk("write_ignored_counts", timer_counter, 64'd27);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
